// File: rtl/route_engine.sv
// ---------------------------------------------------------------------------
// route_engine
//
// Single-input mesh router stage. A header flit picks one of five output
// channels. The header and every following flit up to s_tlast go to that
// channel through a 2-entry skid buffer. Flits that arrive outside a packet
// (non-header type while idle) are accepted and discarded, and a saturating
// counter records them.
//
// Build option:
//   ROUTE_YX_ORDER_EN  defined   -> YX dimension order (north/south first)
//                      undefined -> XY dimension order (east/west first)
//
// Ports:
//   clk          single clock
//   rst          asynchronous, active-high reset
//   s_tvalid     input stream valid
//   s_tready     input stream ready (registered, low while skid entry full)
//   s_tdata      input flit, type field in the top PACKET_TYPE_WIDTH bits
//   s_tlast      input end-of-packet marker
//   m_tvalid     per-channel valid (0 local, 1 north, 2 east, 3 south, 4 west)
//   m_tready     per-channel ready, only the active channel's bit is used
//   m_tdata      output flit shared by all channels
//   m_tlast      output end-of-packet shared by all channels
//   lock_o       one-hot channel owned by the packet in flight
//   drop_cnt_o   saturating count of discarded flits
// ---------------------------------------------------------------------------
module route_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int PACKET_TYPE_WIDTH = 4,
  parameter logic [PACKET_TYPE_WIDTH-1:0] ROUTING_HEADER = 4'hA,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0,
  parameter int X_LSB = 0,
  parameter int Y_LSB = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  output logic [4:0]            m_tvalid,
  input  logic [4:0]            m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [4:0]            lock_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int CHANNEL_NUMBER = 5;
  localparam int XW = $clog2(MAX_ROUTERS_X);
  localparam int YW = $clog2(MAX_ROUTERS_Y);

  localparam logic [XW-1:0] OWN_X = XW'(ROUTER_X);
  localparam logic [YW-1:0] OWN_Y = YW'(ROUTER_Y);

  localparam logic [CHANNEL_NUMBER-1:0] CH_LOCAL = 5'b00001;
  localparam logic [CHANNEL_NUMBER-1:0] CH_NORTH = 5'b00010;
  localparam logic [CHANNEL_NUMBER-1:0] CH_EAST  = 5'b00100;
  localparam logic [CHANNEL_NUMBER-1:0] CH_SOUTH = 5'b01000;
  localparam logic [CHANNEL_NUMBER-1:0] CH_WEST  = 5'b10000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FWD  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [XW-1:0]             target_x;
  logic [YW-1:0]             target_y;
  logic                      is_header;
  logic                      s_hs;
  logic                      push;
  logic                      drop;
  logic [CHANNEL_NUMBER-1:0] route_ch;
  logic [CHANNEL_NUMBER-1:0] push_ch;
  logic [CHANNEL_NUMBER-1:0] lock_next;

  logic                      out_valid;
  logic [CHANNEL_NUMBER-1:0] out_ch;
  logic [DATA_WIDTH-1:0]     out_data;
  logic                      out_last;
  logic                      skid_valid;
  logic                      skid_valid_next;
  logic [CHANNEL_NUMBER-1:0] skid_ch;
  logic [DATA_WIDTH-1:0]     skid_data;
  logic                      skid_last;
  logic                      out_take;
  logic                      load_out;

  assign target_x  = s_tdata[X_LSB +: XW];
  assign target_y  = s_tdata[Y_LSB +: YW];
  assign is_header = (s_tdata[DATA_WIDTH-1 -: PACKET_TYPE_WIDTH] == ROUTING_HEADER);
  assign s_hs      = s_tvalid & s_tready;

  // Dimension-ordered routing on unsigned coordinates; the first differing
  // dimension decides the direction, a full match delivers locally.
  always_comb begin
    route_ch = CH_LOCAL;
`ifdef ROUTE_YX_ORDER_EN
    if (target_y != OWN_Y) begin
      route_ch = (target_y > OWN_Y) ? CH_SOUTH : CH_NORTH;
    end else if (target_x != OWN_X) begin
      route_ch = (target_x > OWN_X) ? CH_EAST : CH_WEST;
    end
`else
    if (target_x != OWN_X) begin
      route_ch = (target_x > OWN_X) ? CH_EAST : CH_WEST;
    end else if (target_y != OWN_Y) begin
      route_ch = (target_y > OWN_Y) ? CH_SOUTH : CH_NORTH;
    end
`endif
  end

  // lock_o doubles as the latched route while a packet is in flight. In IDLE
  // it is forced to zero so a single-flit packet leaves a one-cycle pulse.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    drop       = 1'b0;
    push_ch    = lock_o;
    lock_next  = lock_o;
    case (state)
      IDLE: begin
        lock_next = '0;
        if (s_hs) begin
          if (is_header) begin
            push      = 1'b1;
            push_ch   = route_ch;
            lock_next = route_ch;
            if (!s_tlast) state_next = FWD;
          end else begin
            drop = 1'b1;
          end
        end
      end
      FWD: begin
        if (s_hs) begin
          push = 1'b1;
          if (s_tlast) begin
            state_next = IDLE;
            lock_next  = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lock_o     <= '0;
      drop_cnt_o <= '0;
    end else begin
      state  <= state_next;
      lock_o <= lock_next;
      if (drop && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // The output register refills whenever it is empty or being taken. A new
  // flit lands in the skid entry only when the output is stalled. s_tready is
  // cleared while the skid entry is occupied, so a push never coincides with a
  // full skid entry.
  assign out_take = out_valid & (|(out_ch & m_tready));
  assign load_out = ~out_valid | out_take;

  always_comb begin
    skid_valid_next = load_out ? 1'b0 : (skid_valid | push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_tready   <= 1'b0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_ch    <= '0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else begin
      s_tready   <= ~skid_valid_next;
      skid_valid <= skid_valid_next;
      if (load_out) begin
        if (skid_valid) begin
          out_valid <= 1'b1;
          out_ch    <= skid_ch;
          out_data  <= skid_data;
          out_last  <= skid_last;
        end else if (push) begin
          out_valid <= 1'b1;
          out_ch    <= push_ch;
          out_data  <= s_tdata;
          out_last  <= s_tlast;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (push) begin
        skid_ch   <= push_ch;
        skid_data <= s_tdata;
        skid_last <= s_tlast;
      end
    end
  end

  assign m_tvalid = out_ch & {CHANNEL_NUMBER{out_valid}};
  assign m_tdata  = out_data;
  assign m_tlast  = out_last;

endmodule

// File: tb/tb_route_engine.sv
// ---------------------------------------------------------------------------
// tb_route_engine
//
// Bench for route_engine placed at mesh position (1,1). A reference model
// tracks packets at flit level with a queue of expected outputs, and a
// monitor compares every DUT handshake against it. Directed cases cover
// reset, XY/YX routing, single-flit packets, drops, back-pressure, and reset
// mid-packet. A randomized phase and a drop-counter saturation run follow.
// ---------------------------------------------------------------------------
module tb_route_engine;

  localparam int RX = 1;
  localparam int RY = 1;

`ifdef ROUTE_YX_ORDER_EN
  localparam logic [4:0] CH_2_2 = 5'b01000;
`else
  localparam logic [4:0] CH_2_2 = 5'b00100;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic [4:0]  m_tvalid;
  logic [4:0]  m_tready = 5'h1F;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [4:0]  lock_o;
  logic [15:0] drop_cnt_o;

  logic [4:0]  ready_fixed = 5'h1F;
  bit          rand_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  ch;
    logic [31:0] data;
    logic        last;
  } flit_t;

  flit_t       exp_q[$];
  flit_t       mon_e;
  bit          in_pkt = 1'b0;
  bit          hdr_pulse;
  logic [4:0]  cur_ch = '0;
  logic [4:0]  exp_lock = '0;
  int          exp_drops = 0;
  bit          just_reset = 1'b0;
  bit          hold_valid = 1'b0;
  logic [4:0]  hold_v;
  logic [31:0] hold_d;
  logic        hold_l;

  route_engine #(
    .ROUTER_X(RX),
    .ROUTER_Y(RY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata(s_tdata),
    .s_tlast(s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata(m_tdata),
    .m_tlast(m_tlast),
    .lock_o(lock_o),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Target channel from mesh geometry: compare coordinates numerically and
  // take the first dimension that differs.
  function automatic logic [4:0] expChannel(input logic [31:0] d);
    int tx, ty, dir;
    tx = int'(d[1:0]);
    ty = int'(d[9:8]);
`ifdef ROUTE_YX_ORDER_EN
    if (ty > RY)      dir = 3;
    else if (ty < RY) dir = 1;
    else if (tx > RX) dir = 2;
    else if (tx < RX) dir = 4;
    else              dir = 0;
`else
    if (tx > RX)      dir = 2;
    else if (tx < RX) dir = 4;
    else if (ty > RY) dir = 3;
    else if (ty < RY) dir = 1;
    else              dir = 0;
`endif
    return 5'(1 << dir);
  endfunction

  // Reference model and output monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      in_pkt     = 1'b0;
      exp_lock   = '0;
      exp_drops  = 0;
      hold_valid = 1'b0;
      just_reset = 1'b1;
    end else begin
      if (just_reset) begin
        checkOutput("s_tready_first_cycle", 32'(s_tready), 32'd0);
        just_reset = 1'b0;
      end else begin
        checkOutput("s_tready", 32'(s_tready), (exp_q.size() < 2) ? 32'd1 : 32'd0);
      end
      checkOutput("valid_present", 32'(m_tvalid != 5'd0), 32'(exp_q.size() != 0));
      checkOutput("lock_o", 32'(lock_o), 32'(exp_lock));
      checkOutput("drop_cnt", 32'(drop_cnt_o), 32'(exp_drops));
      if (hold_valid) begin
        checkOutput("hold_tvalid", 32'(m_tvalid), 32'(hold_v));
        checkOutput("hold_tdata", m_tdata, hold_d);
        checkOutput("hold_tlast", 32'(m_tlast), 32'(hold_l));
      end
      if (((m_tvalid & m_tready) != 5'd0) && (exp_q.size() != 0)) begin
        mon_e = exp_q.pop_front();
        checkOutput("out_channel", 32'(m_tvalid), 32'(mon_e.ch));
        checkOutput("out_data", m_tdata, mon_e.data);
        checkOutput("out_last", 32'(m_tlast), 32'(mon_e.last));
      end
      hold_valid = (m_tvalid != 5'd0) && ((m_tvalid & m_tready) == 5'd0);
      hold_v = m_tvalid;
      hold_d = m_tdata;
      hold_l = m_tlast;

      hdr_pulse = 1'b0;
      if (s_tvalid && s_tready) begin
        if (!in_pkt) begin
          if (s_tdata[31:28] == 4'hA) begin
            cur_ch = expChannel(s_tdata);
            exp_q.push_back('{cur_ch, s_tdata, s_tlast});
            in_pkt    = !s_tlast;
            hdr_pulse = s_tlast;
          end else if (exp_drops < 65535) begin
            exp_drops++;
          end
        end else begin
          exp_q.push_back('{cur_ch, s_tdata, s_tlast});
          if (s_tlast) in_pkt = 1'b0;
        end
      end
      exp_lock = (in_pkt || hdr_pulse) ? cur_ch : 5'd0;
    end
  end

  // Output back-pressure driver: fixed pattern or random per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_tready = rand_ready ? 5'($urandom) : ready_fixed;
    end
  end

  // Offer one flit and hold it until accepted; starts and ends 1 after a rising edge.
  task automatic applyStimulus(input logic [31:0] d, input logic l);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    while (!got && n < 200) begin
      @(negedge clk);
      got = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid = 1'b0;
    checkOutput("accept_in_time", 32'(got), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
    checkOutput({tag, "_m_tdata"}, m_tdata, 32'd0);
    checkOutput({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
    checkOutput({tag, "_lock_o"}, 32'(lock_o), 32'd0);
    checkOutput({tag, "_drop_cnt"}, 32'(drop_cnt_o), 32'd0);
    checkOutput({tag, "_s_tready"}, 32'(s_tready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Multi-flit packet to (2,2); the body carries a header-typed flit too.
    $display("[TB] packet to (2,2)");
    applyStimulus(32'hA000_0202, 1'b0);
    @(negedge clk);
    checkOutput("p22_header_channel", 32'(m_tvalid), 32'(CH_2_2));
    checkOutput("p22_lock", 32'(lock_o), 32'(CH_2_2));
    @(posedge clk);
    #1;
    applyStimulus(32'h3000_0011, 1'b0);
    applyStimulus(32'hA000_0022, 1'b1);
    @(negedge clk);
    checkOutput("p22_last_channel", 32'(m_tvalid), 32'(CH_2_2));
    checkOutput("p22_last_data", m_tdata, 32'hA000_0022);
    checkOutput("p22_last_flag", 32'(m_tlast), 32'd1);
    checkOutput("p22_lock_cleared", 32'(lock_o), 32'd0);
    @(posedge clk);
    #1;
    drain();

    // Single-flit packet addressed to this router.
    $display("[TB] local single-flit packet");
    applyStimulus(32'hA000_0101, 1'b1);
    @(negedge clk);
    checkOutput("local_channel", 32'(m_tvalid), 32'd1);
    checkOutput("local_lock_pulse", 32'(lock_o), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("local_lock_gone", 32'(lock_o), 32'd0);
    checkOutput("local_no_repeat", 32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;

    // Non-header flit while idle is discarded.
    $display("[TB] drop in idle");
    checkOutput("drop_before", 32'(drop_cnt_o), 32'd0);
    applyStimulus(32'h5000_0000, 1'b1);
    @(negedge clk);
    checkOutput("drop_after", 32'(drop_cnt_o), 32'd1);
    checkOutput("drop_not_forwarded", 32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;

    // Back-pressure on the packet's channel for four cycles.
    $display("[TB] back-pressure");
    fork
      begin
        applyStimulus(32'hA000_0202, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(32'h3000_0100 + 32'(i), i == 4);
      end
      begin
        ready_fixed = 5'h1F & ~CH_2_2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("stall_s_tready", 32'(s_tready), 32'd0);
        checkOutput("stall_channel", 32'(m_tvalid), 32'(CH_2_2));
        checkOutput("stall_data", m_tdata, 32'hA000_0202);
        @(posedge clk);
        #1;
        ready_fixed = 5'h1F;
      end
    join
    drain();

    // Randomized packets, junk flits and random back-pressure.
    $display("[TB] random traffic");
    rand_ready = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int len;
      logic [31:0] d;
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom;
        if (d[31:28] == 4'hA) d[31:28] = 4'h5;
        applyStimulus(d, 1'($urandom_range(0, 1)));
      end
      d = $urandom;
      d[31:28] = 4'hA;
      len = $urandom_range(0, 3);
      applyStimulus(d, len == 0);
      for (int b = 1; b <= len; b++) begin
        d = $urandom;
        applyStimulus(d, b == len);
      end
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_ready = 1'b0;
    drain();

    // Reset in the middle of a packet; the tail becomes drops.
    $display("[TB] reset mid-packet");
    applyStimulus(32'hA000_0002, 1'b0);
    applyStimulus(32'h3000_0001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs("midpkt_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(32'h3000_0002, 1'b0);
    applyStimulus(32'h3000_0003, 1'b1);
    @(negedge clk);
    checkOutput("tail_drops", 32'(drop_cnt_o), 32'd2);
    checkOutput("tail_not_forwarded", 32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;

    // Drop counter saturation.
    $display("[TB] drop counter saturation");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tdata  = 32'h5000_0000;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    checkOutput("drop_saturated", 32'(drop_cnt_o), 32'h0000_FFFF);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/route_engine.md
ROUTE_ENGINE -- requirements
Module: route_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: flit width.
REQ-002 SHALL have parameter PACKET_TYPE_WIDTH, default 4: type field width, at TDATA[DATA_WIDTH-1 -: PACKET_TYPE_WIDTH].
REQ-003 SHALL have parameter ROUTING_HEADER, default 4'hA: type value marking a header flit.
REQ-004 SHALL have parameters MAX_ROUTERS_X and MAX_ROUTERS_Y, default 4 each; XW/YW = $clog2 of each.
REQ-005 SHALL have parameters ROUTER_X and ROUTER_Y, default 0: own mesh coordinates.
REQ-006 SHALL have parameters X_LSB, default 0, and Y_LSB, default 8: header bit offsets of target_x[XW] and target_y[YW].
REQ-007 SHALL have localparam CHANNEL_NUMBER = 5, with channels 0 local, 1 north (y<), 2 east (x>), 3 south (y>), 4 west (x<).
REQ-008 SHALL have port clk, input, 1: the single clock.
REQ-009 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have ports s_tvalid (in, 1), s_tready (out, 1), s_tdata (in, DATA_WIDTH) and s_tlast (in, 1): the input stream.
REQ-011 SHALL have ports m_tvalid (out, 5), m_tready (in, 5), m_tdata (out, DATA_WIDTH) and m_tlast (out, 1): the output streams, with m_tdata and m_tlast shared by all channels.
REQ-012 SHALL have port lock_o, out, 5: one-hot channel currently owned by the in-flight packet.
REQ-013 SHALL have port drop_cnt_o, out, 16: saturating count of discarded flits.

Function
REQ-014 SHALL implement FSM states IDLE (awaiting header) and FWD (forwarding body).
REQ-015 In IDLE, an accepted flit whose type equals ROUTING_HEADER SHALL latch the route, set lock_o, and go to FWD; with s_tlast=1 it SHALL stay in IDLE and lock_o SHALL pulse for one cycle.
REQ-016 In IDLE, an accepted non-header flit SHALL be discarded and drop_cnt_o incremented (saturating at 16'hFFFF).
REQ-017 In FWD, every accepted flit SHALL go to the latched channel regardless of its type; acceptance with s_tlast=1 SHALL return to IDLE and clear lock_o the next cycle.
REQ-018 Default routing SHALL be XY: target_x!=ROUTER_X selects east/west; else target_y!=ROUTER_Y selects south/north; else local.
REQ-019 Coordinates SHALL be compared unsigned at widths XW and YW.
REQ-020 The output SHALL be a 2-entry skid buffer: latency 1 cycle from s handshake to m_tvalid, full throughput with m_tready held high.
REQ-021 s_tready SHALL be registered and SHALL equal NOT(skid entry occupied).
REQ-022 Exactly one m_tvalid bit SHALL be high when the buffer is non-empty, namely the latched channel of the head flit; only that channel's m_tready SHALL be observed.
REQ-023 Once asserted, m_tvalid SHALL hold with m_tdata and m_tlast stable until accepted.
REQ-024 Discarded flits SHALL be accepted (s_tready rules unchanged) and never appear on m_*.

Reset
REQ-025 When rst is asserted, the state SHALL be IDLE and the buffer empty.
REQ-026 When rst is asserted, the outputs SHALL be m_tvalid=0, m_tdata=0, m_tlast=0, lock_o=0, drop_cnt_o=0 and s_tready=0.
REQ-027 s_tready SHALL rise on the first clk edge after rst deasserts.
REQ-028 A reset mid-packet SHALL discard buffered flits; the remainder of that packet SHALL count as drops.

Configuration
REQ-029 Macro ROUTE_YX_ORDER_EN defined: routing SHALL be YX (north/south first, then east/west, else local).
REQ-030 Macro ROUTE_YX_ORDER_EN undefined: routing SHALL be XY per REQ-018.
REQ-031 All other behaviour SHALL be identical with and without ROUTE_YX_ORDER_EN.

Verification (ROUTER_X=1, ROUTER_Y=1, defaults otherwise)
REQ-032 Header 32'hA000_0202 (x=2, y=2) then 2 body flits, last with tlast, m_tready=5'h1F -> all 3 flits on m_tvalid[2], 1-cycle latency, lock_o=5'b00100 until tlast+1.
REQ-033 The same packet with ROUTE_YX_ORDER_EN defined -> all 3 flits on m_tvalid[3].
REQ-034 Header 32'hA000_0101, single flit with tlast -> m_tvalid[0] once, FSM stays IDLE.
REQ-035 Flit 32'h5000_0000 in IDLE -> no m_tvalid, drop_cnt_o 0->1; 65536 drops -> drop_cnt_o holds 16'hFFFF.
REQ-036 m_tready[2]=0 for 4 cycles mid-packet -> s_tready low after 2 flits are buffered, no loss or reorder, data stable throughout.
REQ-037 rst pulse during FWD -> all outputs 0, IDLE; trailing body flits are counted as drops.
